// File: rtl/alu_if.sv
// Request/response bundle between the issue stage and alu_core.
// The master drives the request; the slave returns handshake, result and flags.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  ready, valid, result, zero, carry, illegal
    );

    modport slave (
        input  start, op, a, b,
        output ready, valid, result, zero, carry, illegal
    );
endinterface

// File: rtl/alu_core.sv
// 16-bit ALU: single-cycle logic/add/sub/shift, optional 16-step shift-add multiply.
// Define ALU_MUL_EN to build the multiplier; otherwise op 111 completes flagged illegal.
module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic             accept;
    logic             single_accept;
    logic             ready_int;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ill;

    logic             valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             illegal_reg;

    assign accept = bus.start && ready_int;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ill   = 1'b0;
        case (bus.op)
            OP_ADD: {alu_carry, alu_res} = {1'b0, bus.a} + {1'b0, bus.b};
            OP_SUB: begin
                alu_res   = bus.a - bus.b;
                alu_carry = (bus.a >= bus.b);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SLL: alu_res = bus.a << bus.b[3:0];
            OP_SRL: alu_res = bus.a >> bus.b[3:0];
            default: alu_ill = 1'b1;  // only reaches the output when no multiplier is built
        endcase
    end

`ifdef ALU_MUL_EN
    localparam bit MUL_BUILT = 1'b1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_reg, state_next;
    logic             ready_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [3:0]       cnt_reg;
    logic [WIDTH-1:0] mul_sum;
    logic             mul_start;

    assign mul_start = accept && (bus.op == OP_MUL);
    assign mul_sum   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_res   = mul_sum;
    assign ready_int = ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mul_done   = 1'b0;
        case (state_reg)
            S_IDLE: if (mul_start) state_next = S_MUL;
            S_MUL: begin
                if (cnt_reg == 4'd15) begin
                    mul_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_reg  <= 1'b1;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            ready_reg <= (state_next == S_IDLE);
            if (mul_start) begin
                acc_reg    <= '0;
                cnt_reg    <= '0;
                mcand_reg  <= bus.a;
                mplier_reg <= bus.b;
            end else if (state_reg == S_MUL) begin
                acc_reg    <= mul_sum;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + 4'd1;
            end
        end
    end
`else
    localparam bit MUL_BUILT = 1'b0;

    assign ready_int = 1'b1;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
`endif

    // With the multiplier built, MUL leaves through mul_done instead of the single-cycle path.
    assign single_accept = accept && !(MUL_BUILT && (bus.op == OP_MUL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            carry_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (single_accept) begin
                valid_reg   <= 1'b1;
                result_reg  <= alu_res;
                zero_reg    <= (alu_res == '0);
                carry_reg   <= alu_carry;
                illegal_reg <= alu_ill;
            end else if (mul_done) begin
                valid_reg   <= 1'b1;
                result_reg  <= mul_res;
                zero_reg    <= (mul_res == '0);
                carry_reg   <= 1'b0;
                illegal_reg <= 1'b0;
            end
        end
    end

    assign bus.ready   = ready_int;
    assign bus.valid   = valid_reg;
    assign bus.result  = result_reg;
    assign bus.zero    = zero_reg;
    assign bus.carry   = carry_reg;
    assign bus.illegal = illegal_reg;
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: vector table through a scoreboard, plus
// multiply handshake and reset-abort sequences (multiply parts need ALU_MUL_EN).
module tb_alu_core;
    localparam int WIDTH = 16;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        zero;
        logic        carry;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        zero;
        logic        carry;
        logic        ill;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_if #(.WIDTH(WIDTH)) bus ();
    alu_core #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request for the coming edge; expected response is queued with its due cycle.
    task automatic issue(input vec_t v, input int lat, input bit chk_ready);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        if (chk_ready) chk("ready_at_issue", bus.ready, 1);
        e.res   = v.res;
        e.zero  = v.zero;
        e.carry = v.carry;
        e.ill   = v.ill;
        e.due   = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        bus.start = 1'b0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (bus.valid) begin
            $display("txn cyc=%0d result=0x%04h zero=%0b carry=%0b illegal=%0b",
                     cyc, bus.result, bus.zero, bus.carry, bus.illegal);
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",  bus.result,  e.res);
                chk("zero",    bus.zero,    e.zero);
                chk("carry",   bus.carry,   e.carry);
                chk("illegal", bus.illegal, e.ill);
                chk("latency", cyc,         e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nvalid;
        vec_t v;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;

        tbl.push_back('{OP_ADD, 16'h0000, 16'h000A, 16'h000A, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{OP_SUB, 16'h0005, 16'h000A, 16'hFFFB, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SUB, 16'h000A, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{OP_SUB, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SLL, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SRL, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SRL, 16'hF000, 16'hFFF4, 16'h0F00, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{OP_XOR, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_SLL, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0});
`ifndef ALU_MUL_EN
        tbl.push_back('{OP_MUL, 16'h0003, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b1});
`endif
        tbl.push_back('{OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0});

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready",   bus.ready,   1);
        chk("rst_valid",   bus.valid,   0);
        chk("rst_result",  bus.result,  0);
        chk("rst_zero",    bus.zero,    0);
        chk("rst_carry",   bus.carry,   0);
        chk("rst_illegal", bus.illegal, 0);
        rst = 1'b0;
        @(negedge clk);

        // Whole table back-to-back: one acceptance per edge, valid every cycle.
        for (int i = 0; i < tbl.size(); i++) issue(tbl[i], 1, 1'b1);
        drain();

`ifdef ALU_MUL_EN
        v = '{OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0};
        issue(v, 17, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk("mul_ready_low", bus.ready, 0);
            bus.start = (k == 4);
            bus.op    = OP_ADD;
            bus.a     = 16'h1111;
            bus.b     = 16'h2222;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("mul_ready_back", bus.ready, 1);
        v = '{OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0};
        issue(v, 1, 1'b1);
        drain();

        v = '{OP_MUL, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        issue(v, 17, 1'b1);
        drain();
        v = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
        issue(v, 17, 1'b1);
        drain();
        v = '{OP_ADD, 16'h0100, 16'h0001, 16'h0101, 1'b0, 1'b0, 1'b0};
        issue(v, 1, 1'b1);
        drain();

        v = '{OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0};
        issue(v, 17, 1'b1);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
`endif
        // Reset mid-operation (mid-MUL when the multiplier is built).
        #1 rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_ready",   bus.ready,   1);
        chk("abort_result",  bus.result,  0);
        chk("abort_valid",   bus.valid,   0);
        chk("abort_zero",    bus.zero,    0);
        chk("abort_carry",   bus.carry,   0);
        chk("abort_illegal", bus.illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);

        v = '{OP_SUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b1, 1'b0};
        issue(v, 1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
